mac_tx_arbiter: RTL

MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

---
 rtl/ether_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/mac_tx_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ether_pkg.sv
// rtl/ether_pkg.sv - shared widths, defaults and FSM encoding for the mac_tx arbiter
// Purpose: common constants for mac_tx_arbiter and rr_pick.
//   ETHERTYPE_W / DATA_W : field widths of one frame request
//   IFG_CYCLES_DEFAULT   : 96 bit times at 2 bits per clk
//   ST_*                 : arbiter FSM state encoding
package ether_pkg;

  localparam int ETHERTYPE_W        = 16;
  localparam int DATA_W             = 32;
  localparam int IFG_CYCLES_DEFAULT = 48;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
// Purpose: finds the first asserted request at or above ptr, wrapping modulo N_CLIENTS.
// Ports:
//   req     in  N_CLIENTS  request vector
//   ptr     in  IDX_W      index where the search starts
//   winner  out IDX_W      selected client (0 when no request)
//   any_req out 1          at least one request is high
module rr_pick #(
  parameter int N_CLIENTS = 4,
  parameter int IDX_W     = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_req
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit to ptr is the
  // last assignment and therefore the one that sticks.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_CLIENTS);
      if (req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - round-robin arbiter sharing one mac_tx transmitter
// Purpose: grants one client at a time, launches mac_tx, waits for tx_done or a
// timeout, acknowledges the client and enforces the inter-frame gap.
// Ports:
//   clk, rst_n     in   clock, asynchronous active-low reset
//   req            in   N_CLIENTS per-client level request
//   req_ethertype  in   16*N_CLIENTS per-client ethertype
//   req_data       in   32*N_CLIENTS per-client payload word
//   ack, err       out  N_CLIENTS completion / timeout pulses
//   tx_start       out  one-cycle launch pulse to mac_tx
//   tx_ethertype   out  16 latched ethertype
//   tx_data        out  32 latched payload
//   tx_done        in   completion pulse from mac_tx
//   busy           out  high outside IDLE
module mac_tx_arbiter
  import ether_pkg::*;
#(
  parameter int N_CLIENTS      = 4,
  parameter int IFG_CYCLES     = IFG_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CLIENTS-1:0]          req,
  input  logic [ETHERTYPE_W*N_CLIENTS-1:0] req_ethertype,
  input  logic [DATA_W*N_CLIENTS-1:0]   req_data,
  output logic [N_CLIENTS-1:0]          ack,
  output logic [N_CLIENTS-1:0]          err,
  output logic                          tx_start,
  output logic [ETHERTYPE_W-1:0]        tx_ethertype,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_done,
  output logic                          busy
);

  localparam int IDX_W = $clog2(N_CLIENTS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES - 1) + 1;
  localparam int GAP_W = $clog2(IFG_CYCLES) + 1;

  // Timeout fires on the WAIT_DONE cycle whose increment brings the counter
  // to TIMEOUT_CYCLES-1, so ack lands exactly TIMEOUT_CYCLES after tx_start.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);
  // The ack cycle is the first GAP cycle and is not part of the gap proper,
  // hence IFG_CYCLES+1 GAP cycles in total.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES);

  logic [1:0]             state_q,   state_d;
  logic [IDX_W-1:0]       ptr_q,     ptr_d;
  logic [IDX_W-1:0]       winner_q,  winner_d;
  logic [TO_W-1:0]        to_cnt_q,  to_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [N_CLIENTS-1:0]   ack_q,     ack_d;
  logic [N_CLIENTS-1:0]   err_q,     err_d;
  logic [ETHERTYPE_W-1:0] tx_eth_q,  tx_eth_d;
  logic [DATA_W-1:0]      tx_data_q, tx_data_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [N_CLIENTS-1:0]   winner_hot;

  rr_pick #(
    .N_CLIENTS (N_CLIENTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  assign winner_hot = N_CLIENTS'(1) << winner_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ack_d     = '0;
    err_d     = '0;
    tx_eth_d  = tx_eth_q;
    tx_data_d = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          winner_d  = pick_idx;
          tx_eth_d  = req_ethertype[pick_idx*ETHERTYPE_W +: ETHERTYPE_W];
          tx_data_d = req_data[pick_idx*DATA_W +: DATA_W];
          ptr_d     = (pick_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_d   = ST_START;
        end
      end
      ST_START: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // tx_done takes priority over a coincident timeout.
        if (tx_done) begin
          ack_d     = winner_hot;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q == TO_LAST) begin
            ack_d     = winner_hot;
            err_d     = winner_hot;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end
      default: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      winner_q  <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      tx_eth_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tx_eth_q  <= tx_eth_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign tx_start     = (state_q == ST_START);
  assign busy         = (state_q != ST_IDLE);
  assign tx_ethertype = tx_eth_q;
  assign tx_data      = tx_data_q;

endmodule
